// File: rtl/fir_decimator.sv
// Serial-MAC FIR low-pass filter with integer decimation and runtime-writable taps.
// One shared multiplier evaluates one tap per cycle; a result appears NUM_TAPS+2 cycles after its trigger sample.
module fir_decimator #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 32,
    parameter int DECIM    = 1,
    parameter int SHIFT    = 14
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic signed [DATA_W-1:0]                      sample_in,
    input  logic                                          sample_valid_in,
    output logic                                          ready_out,
    input  logic                                          coef_we_in,
    input  logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0] coef_addr_in,
    input  logic signed [COEF_W-1:0]                      coef_data_in,
    output logic signed [DATA_W-1:0]                      filtered_out,
    output logic                                          data_ready_out,
    output logic                                          overrun_out
);

    localparam int AW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = DATA_W + COEF_W + $clog2(NUM_TAPS);

    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_TAPS - 1);
    localparam logic [DW-1:0] LAST_DECIM = DW'(DECIM - 1);

    localparam logic signed [ACC_W:0] ROUND_BIAS = (ACC_W + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W:0] SAT_MAX    = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN    = (ACC_W + 1)'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic signed [DATA_W-1:0] r_hist [NUM_TAPS];
    logic signed [COEF_W-1:0] r_coef [NUM_TAPS];
    logic [AW-1:0]            r_wrPtr;
    logic [AW-1:0]            r_rdPtr;
    logic [AW-1:0]            r_tap;
    logic [DW-1:0]            r_decimCnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_filtered;
    logic                     r_dataReady;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_trigger;
    logic signed [PW-1:0]     w_histX;
    logic signed [PW-1:0]     w_coefX;
    logic signed [PW-1:0]     w_product;
    logic signed [ACC_W:0]    w_rounded;
    logic signed [ACC_W:0]    w_shifted;
    logic signed [DATA_W-1:0] w_saturated;

    assign w_accept  = sample_valid_in && (r_state == IDLE);
    assign w_trigger = w_accept && (r_decimCnt == LAST_DECIM);

    // Both operands are sign-extended to the full product width, so truncating the product is exact.
    assign w_histX   = PW'(r_hist[r_rdPtr]);
    assign w_coefX   = PW'(r_coef[r_tap]);
    assign w_product = w_histX * w_coefX;

    assign w_rounded = (ACC_W + 1)'(r_acc) + ROUND_BIAS;
    assign w_shifted = w_rounded >>> SHIFT;

    always_comb begin
        w_saturated = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_saturated = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_saturated = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_trigger) w_nextState = MAC;
            MAC:     if (r_tap == LAST_IDX) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_hist[i] <= '0;
                r_coef[i] <= (i == 0) ? COEF_W'(2 ** SHIFT) : '0;
            end
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_tap       <= '0;
            r_decimCnt  <= '0;
            r_acc       <= '0;
            r_filtered  <= '0;
            r_dataReady <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_dataReady <= 1'b0;
            r_overrun   <= sample_valid_in && (r_state != IDLE);

            // Tap updates are only honoured while idle so a running MAC sees a stable coefficient set.
            if (coef_we_in && (r_state == IDLE) && (coef_addr_in <= LAST_IDX)) begin
                r_coef[coef_addr_in] <= coef_data_in;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hist[r_wrPtr] <= sample_in;
                        r_wrPtr         <= (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + AW'(1);
                        if (w_trigger) begin
                            r_decimCnt <= '0;
                            r_acc      <= '0;
                            r_tap      <= '0;
                            r_rdPtr    <= r_wrPtr;
                        end else begin
                            r_decimCnt <= r_decimCnt + DW'(1);
                        end
                    end
                end
                MAC: begin
                    r_acc   <= r_acc + ACC_W'(w_product);
                    r_tap   <= r_tap + AW'(1);
                    r_rdPtr <= (r_rdPtr == '0) ? LAST_IDX : r_rdPtr - AW'(1);
                end
                DONE: begin
                    r_filtered  <= w_saturated;
                    r_dataReady <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_out      = (r_state == IDLE);
    assign filtered_out   = r_filtered;
    assign data_ready_out = r_dataReady;
    assign overrun_out    = r_overrun;

endmodule
